bullet_bill_launcher: RTL and testbench
=======================================

Name: bullet_bill_launcher

Overview:
- Owns the three BulletBill slots on the 16x12 battlefield grid (40-pixel blocks, 640x480).
- Accepts fire requests from the input/controller stage and spawns each bullet in the column right of Blockieee.
- Advances every live bullet one column per movement tick and retires bullets at the right edge or on a collision kill.
- Drives the bulletBill colour and X/Y location arrays consumed directly by graphics_generator; colour 12'd0 means slot empty.

Parameters:
- NUM_BULLETS, 3, slot count (graphics_generator consumes exactly 3)
- TICK_DIV, 3_125_000, clk cycles per movement tick (8 moves/s at 25 MHz)
- COOLDOWN_TICKS, 2, movement ticks after an accepted fire before the next fire can be accepted
- SPAWN_COL, 2, column a new bullet appears in
- LAST_COL, 15, rightmost grid column; a bullet at LAST_COL retires on the next tick

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- fire_req  input  1  fire request, level, held until fire_ack
- fire_color  input  12  RGB444 colour of the requested bullet
- player_row  input  4  current Blockieee row, 0..11
- kill_valid  input  1  one-cycle collision kill strobe
- kill_slot  input  2  slot index to clear when kill_valid
- fire_ack  output  1  one-cycle pulse; the request was accepted this cycle
- bullet_color  output  12 x NUM_BULLETS  per-slot colour; 0 = inactive
- bullet_x  output  4 x NUM_BULLETS  per-slot column
- bullet_y  output  4 x NUM_BULLETS  per-slot row
- slots_full  output  1  all slots active (combinational from slot state)
- move_tick  output  1  one-cycle strobe when bullets advance (for collision logic)

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high, port names clk and rst.
- Reset: all bullet_color=0, bullet_x=0, bullet_y=0, fire_ack=0, move_tick=0, tick counter=0, cooldown=0, FSM=READY.
- Reset mid-flight clears all slots immediately; there is no partial retirement.
- Tick divider: counter 0..TICK_DIV-1. move_tick=1 for the one cycle in which the counter wraps to 0.
- FSM has two states:
  - READY: accept when fire_req=1, fire_color!=0, player_row<=11 and at least one slot is free. Otherwise no ack; the request stays pending.
  - COOLDOWN: entered on accept with cooldown=COOLDOWN_TICKS. It decrements on each move_tick and returns to READY in the cycle the count reaches 0. fire_req is ignored in this state.
- Accept, same cycle:
  - fire_ack=1 (registered, visible the next cycle, together with the slot update).
  - Target slot = lowest-index free slot, with free judged on the pre-update state.
  - The slot loads color=fire_color, x=SPAWN_COL, y=player_row.
  - The spawned bullet does not move on a coincident move_tick.
- Movement on move_tick, for each active slot not being spawned:
  - if x==LAST_COL, set color=0 and hold x/y (retire);
  - otherwise x=x+1.
  - All 4-bit, unsigned. x never wraps past 15.
- Kill: when kill_valid=1, slot kill_slot sets color=0 next cycle.
  - Kill has priority over movement on the same slot.
  - kill_slot>=NUM_BULLETS or an inactive target: no effect.
- Kill coincident with a fire accept: free-slot selection uses the pre-kill state, so the killed slot is not reused that cycle.
- Outputs: all outputs are registered except slots_full. The latency from fire_req to a visible bullet is 1 cycle.
- Inactive slots keep stale x/y. Consumers must gate on color!=0, which graphics_generator already does.

Decomposition:
- Shared package battlefield_pkg:
  - GRID_COLS=16, GRID_ROWS=12, BSIZE=40, HOME_COL=0, PLAYER_COL=1;
  - typedef rgb444_t (12 bits) and typedef grid_idx_t (4 bits);
  - typedef bullet_t struct {rgb444_t color; grid_idx_t x; grid_idx_t y}.
- One sub-module, tick_divider (parameter TICK_DIV, outputs move_tick). It is reusable by the DDAVER advance logic.
- Slot array and FSM stay in bullet_bill_launcher.

Test Plan:
- Reset:
  - Stimulus: reset, then fire_req=1, fire_color=12'hF00, player_row=5.
  - Required: fire_ack pulses once; slot0 = {F00, x=2, y=5}; slots 1 and 2 color 0.
- Flight and retirement (TICK_DIV=4):
  - Stimulus: one fired bullet, observe 14 move_ticks.
  - Required: x reaches 15 after 13 ticks; color becomes 0 on tick 14.
- Fill and reject (COOLDOWN_TICKS=0):
  - Stimulus: three accepts.
  - Required: slots_full=1; a fourth fire_req gets no ack.
  - Stimulus: kill_valid with kill_slot=1.
  - Required: the next request lands in slot 1.
- Cooldown (COOLDOWN_TICKS=2):
  - Stimulus: accept, then fire_req held.
  - Required: the second ack arrives only in the cycle after the 2nd move_tick following the first accept.
- Coincident events:
  - Stimulus: fire accept, move_tick, and kill of active slot0 in the same cycle.
  - Required: the new bullet goes to slot1 at x=2 with no advance; slot0 is cleared and not moved.
- Invalid inputs:
  - Stimulus: fire_color=0, or player_row=12, or kill_slot=3.
  - Required: no ack and no state change; pending request accepted once inputs become valid.

Source files
------------

// File: rtl/battlefield_pkg.sv
// ---------------------------------------------------------------------------
// battlefield_pkg
// Shared definitions for the 16x12 battlefield grid (40-pixel blocks on a
// 640x480 screen). Used by the bullet launcher and by any other block that
// places objects on the grid.
//   - grid geometry constants
//   - rgb444_t   : 12-bit RGB444 colour, 12'd0 means "nothing drawn"
//   - grid_idx_t : 4-bit grid column/row index
//   - bullet_t   : one bullet slot (colour, column, row)
// ---------------------------------------------------------------------------
package battlefield_pkg;

    localparam int GRID_COLS  = 16;
    localparam int GRID_ROWS  = 12;
    localparam int BSIZE      = 40;
    localparam int HOME_COL   = 0;
    localparam int PLAYER_COL = 1;

    typedef logic [11:0] rgb444_t;
    typedef logic [3:0]  grid_idx_t;

    typedef struct packed {
        rgb444_t   color;
        grid_idx_t x;
        grid_idx_t y;
    } bullet_t;

    // A colour of zero marks an empty slot; graphics_generator gates on it.
    localparam rgb444_t   COLOR_NONE = 12'd0;
    localparam grid_idx_t MAX_ROW    = 4'(GRID_ROWS - 1);

    function automatic logic slot_active(input bullet_t b);
        return (b.color != COLOR_NONE);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Free-running divider producing a one-cycle strobe every TICK_DIV clocks.
// The counter runs 0..TICK_DIV-1; move_tick is high for the single cycle in
// which the counter has just wrapped back to 0. Shared with the DDAVER
// advance logic.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   move_tick out  registered one-cycle movement strobe
// ---------------------------------------------------------------------------
module tick_divider #(
    parameter int TICK_DIV = 3_125_000
) (
    input  logic clk,
    input  logic rst,
    output logic move_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Divider counter and wrap strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= '0;
            move_tick <= 1'b0;
        end else if (count_r == CNT_LAST) begin
            count_r   <= '0;
            move_tick <= 1'b1;
        end else begin
            count_r   <= count_r + CNT_ONE;
            move_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/bullet_bill_launcher.sv
// ---------------------------------------------------------------------------
// bullet_bill_launcher
// Owns the BulletBill slots on the battlefield grid. Accepts fire requests,
// spawns a bullet in the column right of Blockieee, advances live bullets one
// column per movement tick, and retires them at the right edge or on a
// collision kill. The slot arrays feed graphics_generator directly.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   fire_req     in   level fire request, held until fire_ack
//   fire_color   in   RGB444 colour of the requested bullet
//   player_row   in   current Blockieee row (0..11 valid)
//   kill_valid   in   one-cycle collision kill strobe
//   kill_slot    in   slot to clear when kill_valid
//   fire_ack     out  one-cycle pulse, request accepted (registered)
//   bullet_color out  per-slot colour, slot i at [12*i +: 12], 0 = empty
//   bullet_x     out  per-slot column, slot i at [4*i +: 4]
//   bullet_y     out  per-slot row,    slot i at [4*i +: 4]
//   slots_full   out  every slot active (combinational from slot state)
//   move_tick    out  one-cycle strobe, bullets advance on this cycle's edge
// ---------------------------------------------------------------------------
module bullet_bill_launcher
    import battlefield_pkg::*;
#(
    parameter int NUM_BULLETS    = 3,
    parameter int TICK_DIV       = 3_125_000,
    parameter int COOLDOWN_TICKS = 2,
    parameter int SPAWN_COL      = PLAYER_COL + 1,
    parameter int LAST_COL       = GRID_COLS - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fire_req,
    input  logic [11:0]               fire_color,
    input  logic [3:0]                player_row,
    input  logic                      kill_valid,
    input  logic [1:0]                kill_slot,
    output logic                      fire_ack,
    output logic [12*NUM_BULLETS-1:0] bullet_color,
    output logic [4*NUM_BULLETS-1:0]  bullet_x,
    output logic [4*NUM_BULLETS-1:0]  bullet_y,
    output logic                      slots_full,
    output logic                      move_tick
);

    localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    localparam logic [0:0] ST_READY    = 1'b0;
    localparam logic [0:0] ST_COOLDOWN = 1'b1;

    localparam grid_idx_t       SPAWN_X = grid_idx_t'(SPAWN_COL);
    localparam grid_idx_t       LAST_X  = grid_idx_t'(LAST_COL);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_TICKS);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

    bullet_t                slot_r [NUM_BULLETS];
    bullet_t                slot_s [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] active_s;
    logic [NUM_BULLETS-1:0] kill_hit_s;
    logic [NUM_BULLETS-1:0] take_s;
    logic                   free_found_s;
    logic [IDX_W-1:0]       free_idx_s;
    logic                   color_ok_s;
    logic                   row_ok_s;
    logic                   accept_s;
    logic [0:0]             state_r;
    logic [0:0]             state_s;
    logic [CD_W-1:0]        cooldown_r;
    logic [CD_W-1:0]        cooldown_s;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk       (clk),
        .rst       (rst),
        .move_tick (move_tick)
    );

    // Per-slot activity and kill decode; an out-of-range or empty target
    // matches no slot and is therefore ignored.
    always_comb begin
        active_s   = '0;
        kill_hit_s = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            active_s[i]   = slot_active(slot_r[i]);
            kill_hit_s[i] = kill_valid && (int'(kill_slot) == i) && active_s[i];
        end
    end

    // Lowest-index free slot, judged on the registered (pre-kill) state so a
    // slot being killed this cycle is not reused until the next one.
    always_comb begin
        take_s       = '0;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            take_s[i]    = !free_found_s && !active_s[i];
            free_idx_s   = take_s[i] ? IDX_W'(i) : free_idx_s;
            free_found_s = free_found_s | take_s[i];
        end
    end

    assign color_ok_s = (fire_color != COLOR_NONE);
    assign row_ok_s   = (player_row <= MAX_ROW);
    assign accept_s   = (state_r == ST_READY) && fire_req && color_ok_s
                        && row_ok_s && free_found_s;
    assign slots_full = &active_s;

    // Next slot contents: spawn beats kill beats movement. The spawned slot
    // was free, so a spawn and a kill can never target the same slot.
    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            slot_s[i] = slot_r[i];
            if (accept_s && (free_idx_s == IDX_W'(i))) begin
                slot_s[i].color = fire_color;
                slot_s[i].x     = SPAWN_X;
                slot_s[i].y     = player_row;
            end else if (kill_hit_s[i]) begin
                slot_s[i].color = COLOR_NONE;
            end else if (move_tick && active_s[i]) begin
                if (slot_r[i].x == LAST_X) begin
                    // Retire in place; x/y stay stale behind a zero colour.
                    slot_s[i].color = COLOR_NONE;
                end else begin
                    slot_s[i].x = slot_r[i].x + 4'd1;
                end
            end else begin
                slot_s[i] = slot_r[i];
            end
        end
    end

    // Fire FSM: READY accepts, COOLDOWN counts movement ticks back to READY.
    always_comb begin
        state_s    = state_r;
        cooldown_s = cooldown_r;
        case (state_r)
            ST_READY: begin
                if (accept_s) begin
                    cooldown_s = CD_LOAD;
                    // A zero cooldown never leaves READY.
                    state_s    = (COOLDOWN_TICKS == 0) ? ST_READY : ST_COOLDOWN;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_COOLDOWN: begin
                if (move_tick) begin
                    if (cooldown_r <= CD_ONE) begin
                        cooldown_s = '0;
                        state_s    = ST_READY;
                    end else begin
                        cooldown_s = cooldown_r - CD_ONE;
                    end
                end else begin
                    cooldown_s = cooldown_r;
                end
            end
            default: begin
                state_s    = ST_READY;
                cooldown_s = '0;
            end
        endcase
    end

    // Slot array, FSM state and acknowledge registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                slot_r[i] <= '0;
            end
            state_r    <= ST_READY;
            cooldown_r <= '0;
            fire_ack   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                slot_r[i] <= slot_s[i];
            end
            state_r    <= state_s;
            cooldown_r <= cooldown_s;
            fire_ack   <= accept_s;
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
        assign bullet_color[12*g +: 12] = slot_r[g].color;
        assign bullet_x[4*g +: 4]       = slot_r[g].x;
        assign bullet_y[4*g +: 4]       = slot_r[g].y;
    end

endmodule

// File: tb/tb_bullet_bill_launcher.sv
// ---------------------------------------------------------------------------
// tb_bullet_bill_launcher
// Two launchers share one stimulus stream: dut 0 with a cooldown of 2 ticks,
// dut 1 with no cooldown, both with a 4-cycle movement tick. A slot-level
// reference model predicts every output of both each cycle; directed steps
// add targeted checks, then a randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_bullet_bill_launcher;

    localparam int TD = 4;
    localparam int NB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fire_req = 1'b0;
    logic [11:0] fire_color = 12'd0;
    logic [3:0]  player_row = 4'd0;
    logic        kill_valid = 1'b0;
    logic [1:0]  kill_slot = 2'd0;

    logic        ack_o   [2];
    logic        tick_o  [2];
    logic        full_o  [2];
    logic [35:0] color_o [2];
    logic [11:0] x_o     [2];
    logic [11:0] y_o     [2];

    bullet_bill_launcher #(.NUM_BULLETS(NB), .TICK_DIV(TD), .COOLDOWN_TICKS(2)) u_dut_cd2 (
        .clk(clk), .rst(rst), .fire_req(fire_req), .fire_color(fire_color),
        .player_row(player_row), .kill_valid(kill_valid), .kill_slot(kill_slot),
        .fire_ack(ack_o[0]), .bullet_color(color_o[0]), .bullet_x(x_o[0]),
        .bullet_y(y_o[0]), .slots_full(full_o[0]), .move_tick(tick_o[0]));

    bullet_bill_launcher #(.NUM_BULLETS(NB), .TICK_DIV(TD), .COOLDOWN_TICKS(0)) u_dut_cd0 (
        .clk(clk), .rst(rst), .fire_req(fire_req), .fire_color(fire_color),
        .player_row(player_row), .kill_valid(kill_valid), .kill_slot(kill_slot),
        .fire_ack(ack_o[1]), .bullet_color(color_o[1]), .bullet_x(x_o[1]),
        .bullet_y(y_o[1]), .slots_full(full_o[1]), .move_tick(tick_o[1]));

    always #5 clk = ~clk;

    // Reference model state: per dut, per slot
    int m_color [2][NB];
    int m_x     [2][NB];
    int m_y     [2][NB];
    int m_cd    [2];
    bit m_ack   [2];
    bit m_tick;
    int k_edges;
    bit last_tick;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int cooldown_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NB; i++) begin
                m_color[d][i] = 0;
                m_x[d][i]     = 0;
                m_y[d][i]     = 0;
            end
            m_cd[d]  = 0;
            m_ack[d] = 1'b0;
        end
        m_tick  = 1'b0;
        k_edges = 0;
    endtask

    // One clock edge worth of behaviour, from current inputs and model state.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int tgt;
            bit acc;
            tgt = -1;
            for (int i = 0; i < NB; i++) begin
                if (tgt < 0 && m_color[d][i] == 0) tgt = i;
            end
            acc = (m_cd[d] == 0) && (fire_req === 1'b1) && (fire_color != 12'd0)
                  && (int'(player_row) < 12) && (tgt >= 0);
            for (int i = 0; i < NB; i++) begin
                if (acc && i == tgt) begin
                    m_color[d][i] = int'(fire_color);
                    m_x[d][i]     = 2;
                    m_y[d][i]     = int'(player_row);
                end else if ((kill_valid === 1'b1) && int'(kill_slot) == i && m_color[d][i] != 0) begin
                    m_color[d][i] = 0;
                end else if (m_tick && m_color[d][i] != 0) begin
                    if (m_x[d][i] == 15) m_color[d][i] = 0;
                    else                 m_x[d][i] = m_x[d][i] + 1;
                end
            end
            m_ack[d] = acc;
            if (acc)                         m_cd[d] = cooldown_of(d);
            else if (m_cd[d] > 0 && m_tick)  m_cd[d] = m_cd[d] - 1;
        end
        k_edges = k_edges + 1;
        m_tick  = ((k_edges % TD) == 0);
    endtask

    function automatic logic [62:0] expect_vec(input int d);
        logic [35:0] c;
        logic [11:0] xs;
        logic [11:0] ys;
        logic        full;
        full = 1'b1;
        for (int i = 0; i < NB; i++) begin
            c[12*i +: 12] = 12'(m_color[d][i]);
            xs[4*i +: 4]  = 4'(m_x[d][i]);
            ys[4*i +: 4]  = 4'(m_y[d][i]);
            if (m_color[d][i] == 0) full = 1'b0;
        end
        return {m_ack[d], m_tick, full, c, xs, ys};
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [62:0] obs;
            logic [62:0] exp;
            obs = {ack_o[d], tick_o[d], full_o[d], color_o[d], x_o[d], y_o[d]};
            exp = expect_vec(d);
            n_cmp++;
            assert (obs === exp) else begin
                n_bad++;
                $error("FAIL outputs dut%0d edge %0d: observed %h expected %h", d, k_edges, obs, exp);
            end
        end
    endtask

    // Advance one clock; inputs must already be set. Ends on the negedge.
    task automatic step();
        last_tick = m_tick;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset from a negedge: outputs must clear without a clock.
    task automatic do_reset(input string tag);
        fire_req   = 1'b0;
        kill_valid = 1'b0;
        rst        = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_color"}, color_o[d], 36'd0);
            chk({tag, "_xy"}, 36'({x_o[d], y_o[d]}), 36'd0);
            chk({tag, "_ack_tick"}, 36'({ack_o[d], tick_o[d]}), 36'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ticks;
        int  n_after;
        int  since;
        bit  got1;
        bit  done;
        int  px0;
        int  px1;
        int  c;

        model_reset();
        @(negedge clk);
        do_reset("rst_init");

        // First fire after reset
        fire_req = 1'b1; fire_color = 12'hF00; player_row = 4'd5;
        step();
        fire_req = 1'b0;
        chk("first_ack", 36'(ack_o[0]), 36'd1);
        chk("first_slot0", 36'({color_o[0][11:0], x_o[0][3:0], y_o[0][3:0]}), 36'({12'hF00, 4'd2, 4'd5}));
        chk("first_slot12_empty", 36'(color_o[0][35:12]), 36'd0);
        step();
        chk("first_ack_one_pulse", 36'(ack_o[0]), 36'd0);

        // Flight to the right edge and retirement
        ticks = 0;
        done  = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            if (last_tick) begin
                ticks++;
                if (ticks == 13)
                    chk("flight_x15", 36'({color_o[0][11:0], x_o[0][3:0]}), 36'({12'hF00, 4'd15}));
                if (ticks == 14) begin
                    chk("flight_retired", 36'(color_o[0][11:0]), 36'd0);
                    done = 1'b1;
                end
            end
        end
        if (!done) chk("flight_timeout", 36'(ticks), 36'd14);

        // Fill and reject on the zero-cooldown launcher
        fire_req = 1'b1; fire_color = 12'h0F0; player_row = 4'd3;
        step(); step(); step();
        chk("fill_full", 36'(full_o[1]), 36'd1);
        step();
        chk("fill_reject_ack", 36'(ack_o[1]), 36'd0);
        fire_req = 1'b0;
        kill_valid = 1'b1; kill_slot = 2'd1;
        step();
        kill_valid = 1'b0;
        chk("kill_slot1", 36'(color_o[1][23:12]), 36'd0);
        fire_req = 1'b1; fire_color = 12'h00F; player_row = 4'd7;
        step();
        fire_req = 1'b0;
        chk("refill_ack", 36'(ack_o[1]), 36'd1);
        chk("refill_slot1", 36'({color_o[1][23:12], y_o[1][7:4]}), 36'({12'h00F, 4'd7}));
        step(); step();

        // Reset mid-flight
        do_reset("rst_mid");

        // Cooldown: second ack one cycle after the 2nd tick following accept
        fire_req = 1'b1; fire_color = 12'h0FF; player_row = 4'd0;
        got1 = 1'b0; done = 1'b0; n_after = 0; since = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (got1 && last_tick) begin
                n_after++;
                since = 0;
            end else begin
                since++;
            end
            if (ack_o[0] === 1'b1) begin
                if (!got1) begin
                    got1 = 1'b1;
                end else begin
                    chk("cooldown_second_ack", 36'({8'(n_after), 8'(since)}), 36'({8'd2, 8'd1}));
                    done = 1'b1;
                end
            end
        end
        if (!done) chk("cooldown_timeout", 36'(got1), 36'd0);
        fire_req = 1'b0;
        step();

        // Coincident fire, tick and kill of slot0
        do_reset("rst_coinc");
        fire_req = 1'b1; fire_color = 12'hF0F; player_row = 4'd9;
        step();
        fire_req = 1'b0;
        c = 0;
        while (!(m_cd[0] == 0 && m_tick) && c < 40) begin
            step();
            c++;
        end
        chk("coinc_setup", 36'(c < 40), 36'd1);
        fire_req = 1'b1; fire_color = 12'hABC; player_row = 4'd4;
        kill_valid = 1'b1; kill_slot = 2'd0;
        px0 = m_x[0][0];
        px1 = m_x[1][0];
        step();
        fire_req = 1'b0; kill_valid = 1'b0;
        chk("coinc_ack", 36'({ack_o[0], ack_o[1]}), 36'd3);
        chk("coinc_slot0_cd2", 36'({color_o[0][11:0], x_o[0][3:0]}), 36'({12'd0, 4'(px0)}));
        chk("coinc_slot0_cd0", 36'({color_o[1][11:0], x_o[1][3:0]}), 36'({12'd0, 4'(px1)}));
        chk("coinc_slot1_cd2", 36'({color_o[0][23:12], x_o[0][7:4], y_o[0][7:4]}), 36'({12'hABC, 4'd2, 4'd4}));
        chk("coinc_slot1_cd0", 36'({color_o[1][23:12], x_o[1][7:4], y_o[1][7:4]}), 36'({12'hABC, 4'd2, 4'd4}));

        // Invalid inputs, then the pending request becomes valid
        c = 0;
        while (m_cd[0] != 0 && c < 40) begin
            step();
            c++;
        end
        chk("invalid_setup", 36'(c < 40), 36'd1);
        fire_req = 1'b1; fire_color = 12'd0; player_row = 4'd3;
        kill_valid = 1'b1; kill_slot = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("invalid_color_noack", 36'({ack_o[0], ack_o[1]}), 36'd0);
        end
        fire_color = 12'h123; player_row = 4'd12;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("invalid_row_noack", 36'({ack_o[0], ack_o[1]}), 36'd0);
        end
        player_row = 4'd6;
        step();
        chk("valid_again_ack", 36'({ack_o[0], ack_o[1]}), 36'd3);
        fire_req = 1'b0; kill_valid = 1'b0;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            fire_req   = 1'($urandom_range(0, 1));
            fire_color = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom);
            player_row = 4'($urandom_range(0, 13));
            kill_valid = ($urandom_range(0, 5) == 0);
            kill_slot  = 2'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
